// File: rtl/press_led_driver_if.sv
// press_led_driver_if
//   Groups the event/status signals between the event sources and the LED driver.
//   Parameter PEND_W sets the width of pending_count.
//   event_pulse   : single-cycle event strobe into the driver
//   ovf_clr       : clears the sticky overflow flag
//   led_out       : registered LED drive
//   busy          : driver is showing a pulse or gap
//   pending_count : events queued but not yet displayed
//   overflow      : sticky, an event was dropped at saturation
//   Modports: master = event source side, slave = LED driver side.
interface press_led_driver_if #(
  parameter int PEND_W = 3
);
  logic              event_pulse;
  logic              ovf_clr;
  logic              led_out;
  logic              busy;
  logic [PEND_W-1:0] pending_count;
  logic              overflow;

  modport master (
    output event_pulse, ovf_clr,
    input  led_out, busy, pending_count, overflow
  );

  modport slave (
    input  event_pulse, ovf_clr,
    output led_out, busy, pending_count, overflow
  );
endinterface

// File: rtl/press_led_driver.sv
// press_led_driver
//   Turns single-cycle press/hit events into human-visible LED pulses: a held ON
//   period followed by a forced OFF gap. Events arriving mid-pulse are queued in a
//   saturating pending counter; a dropped event sets a sticky overflow flag.
//   Timing comes from a free-running prescaler that strobes a tick every
//   2^PRESCALE_W clocks.
// Parameters: PRESCALE_W, ON_TICKS (>=1), GAP_TICKS (>=1), PEND_W
// Ports:
//   clk : system clock, all state on posedge
//   rst : asynchronous, active-high reset
//   io  : press_led_driver_if.slave (event_pulse, ovf_clr in; led_out, busy,
//         pending_count, overflow out)
// Build option: LED_STRETCH_RETRIGGER_EN -- an event during ON restarts the ON
//   period instead of being queued; events during GAP still queue.
module press_led_driver #(
  parameter int PRESCALE_W = 17,
  parameter int ON_TICKS   = 8,
  parameter int GAP_TICKS  = 4,
  parameter int PEND_W     = 3
) (
  input logic                clk,
  input logic                rst,
  press_led_driver_if.slave  io
);

  localparam int TMAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0]     ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]     GAP_LAST = TW'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [PRESCALE_W-1:0] presc;
  logic                tick;
  logic [TW-1:0]       tick_cnt, tick_cnt_nx;
  logic [PEND_W-1:0]   pend, pend_nx;
  logic                ovf, ovf_set;
  logic                led;
  logic                enq, deq;

  assign tick = &presc;

  always_comb begin
    state_nx    = state;
    tick_cnt_nx = tick_cnt;
    enq         = 1'b0;
    deq         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (io.event_pulse) begin
          state_nx    = ST_ON;
          tick_cnt_nx = '0;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (tick_cnt == ON_LAST) begin
            state_nx    = ST_GAP;
            tick_cnt_nx = '0;
          end else begin
            tick_cnt_nx = tick_cnt + TW'(1);
          end
        end
`ifdef LED_STRETCH_RETRIGGER_EN
        // Retrigger beats a coincident final tick: stay ON with a fresh count.
        if (io.event_pulse) begin
          state_nx    = ST_ON;
          tick_cnt_nx = '0;
        end
`else
        enq = io.event_pulse;
`endif
      end
      ST_GAP: begin
        if (tick && (tick_cnt == GAP_LAST)) begin
          tick_cnt_nx = '0;
          if (pend != '0) begin
            // Dequeue; a coincident event is queued in its place.
            state_nx = ST_ON;
            deq      = 1'b1;
            enq      = io.event_pulse;
          end else if (io.event_pulse) begin
            // Nothing queued: the coincident event is shown directly.
            state_nx = ST_ON;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          if (tick) begin
            tick_cnt_nx = tick_cnt + TW'(1);
          end
          enq = io.event_pulse;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        tick_cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    pend_nx = pend;
    ovf_set = 1'b0;
    if (enq && !deq) begin
      if (pend == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_nx = pend + PEND_W'(1);
      end
    end else if (deq && !enq) begin
      pend_nx = pend - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      presc    <= '0;
      tick_cnt <= '0;
      pend     <= '0;
      ovf      <= 1'b0;
      led      <= 1'b0;
    end else begin
      state    <= state_nx;
      presc    <= presc + PRESCALE_W'(1);
      tick_cnt <= tick_cnt_nx;
      pend     <= pend_nx;
      led      <= (state_nx == ST_ON);
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (io.ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign io.led_out       = led;
  assign io.busy          = (state != ST_IDLE);
  assign io.pending_count = pend;
  assign io.overflow      = ovf;

endmodule

// File: tb/tb_press_led_driver.sv
// tb_press_led_driver
//   Directed bench for press_led_driver with PRESCALE_W=2 (tick every 4 clk),
//   ON_TICKS=3, GAP_TICKS=2, PEND_W=2. Expected values are hand-computed; the
//   bench keeps its own edge counter since reset to know where ticks fall
//   (a tick is taken on edge n after reset release when n is a multiple of 4).
module tb_press_led_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cyc;

  press_led_driver_if #(.PEND_W(2)) io ();

  press_led_driver #(
    .PRESCALE_W(2),
    .ON_TICKS  (3),
    .GAP_TICKS (2),
    .PEND_W    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_range(input int v, input int lo, input int hi, input string tag);
    total++;
    assert (v >= lo && v <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
  endtask

  task automatic pulse_event();
    io.event_pulse = 1'b1;
    step();
    io.event_pulse = 1'b0;
  endtask

  task automatic wait_led(input logic val, input int budget, input string tag);
    int n = 0;
    while (io.led_out !== val && n < budget) begin
      step();
      n++;
    end
    check(io.led_out, val, tag);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (io.busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check(io.busy, 1'b0, tag);
  endtask

  task automatic measure_high(output int n, input int budget);
    n = 0;
    while (io.led_out === 1'b1 && n < budget) begin
      n++;
      step();
    end
  endtask

  initial begin
    int len;
    int rises;
    logic prev;

    io.event_pulse = 1'b0;
    io.ovf_clr     = 1'b0;

    // Reset state
    #2;
    check(io.led_out, 1'b0, "rst_led");
    check(io.busy, 1'b0, "rst_busy");
    check(io.pending_count, 2'd0, "rst_pend");
    check(io.overflow, 1'b0, "rst_ovf");
    step();
    step();
    rst = 1'b0;
    step();

    // Single event from IDLE
    pulse_event();
    check(io.led_out, 1'b1, "single_led_on");
    check(io.busy, 1'b1, "single_busy");
    measure_high(len, 40);
    check_range(len, 9, 12, "single_on_len");
    len = 0;
    while (io.busy === 1'b1 && io.led_out === 1'b0 && len < 40) begin
      len++;
      step();
    end
    check_range(len, 5, 8, "single_gap_len");
    check(io.busy, 1'b0, "single_idle_busy");
    check(io.led_out, 1'b0, "single_idle_led");

    // One queued event during ON
    step();
    pulse_event();
    step();
    step();
    pulse_event();
    check(io.pending_count, 2'd1, "q1_pend");
    wait_led(1'b0, 40, "q1_gap");
    check(io.pending_count, 2'd1, "q1_pend_gap");
    wait_led(1'b1, 40, "q1_second_on");
    check(io.pending_count, 2'd0, "q1_pend_after");
    wait_idle(60, "q1_idle");

    // Saturation and overflow
    step();
    pulse_event();
    repeat (5) pulse_event();
    check(io.pending_count, 2'd3, "sat_pend");
    check(io.overflow, 1'b1, "sat_ovf");
    io.ovf_clr = 1'b1;
    pulse_event();
    check(io.overflow, 1'b1, "sat_set_wins");
    check(io.pending_count, 2'd3, "sat_pend_hold");
    step();
    io.ovf_clr = 1'b0;
    check(io.overflow, 1'b0, "sat_ovf_clr");
    rises = 0;
    prev  = io.led_out;
    for (int i = 0; i < 300 && io.busy === 1'b1; i++) begin
      step();
      if (io.led_out === 1'b1 && prev === 1'b0) rises++;
      prev = io.led_out;
    end
    check(rises, 3, "sat_pulses");
    check(io.busy, 1'b0, "sat_idle");
    check(io.pending_count, 2'd0, "sat_pend_end");

    // Event coinciding with GAP->ON dequeue, then with GAP->IDLE.
    // The GAP always starts on a tick edge, so its end lands exactly 8 edges later.
    step();
    pulse_event();
    step();
    pulse_event();
    check(io.pending_count, 2'd1, "co_pend1");
    wait_led(1'b0, 40, "co_gap1");
    repeat (7) step();
    pulse_event();
    check(io.led_out, 1'b1, "co_deq_on");
    check(io.pending_count, 2'd1, "co_deq_pend");
    wait_led(1'b0, 40, "co_gap2");
    wait_led(1'b1, 40, "co_on3");
    check(io.pending_count, 2'd0, "co_pend0");
    wait_led(1'b0, 40, "co_gap3");
    repeat (7) step();
    pulse_event();
    check(io.led_out, 1'b1, "co_idle_on");
    check(io.busy, 1'b1, "co_idle_busy");
    check(io.pending_count, 2'd0, "co_idle_pend");
    wait_idle(60, "co_idle");

    // Asynchronous reset in the middle of ON with two queued
    step();
    pulse_event();
    pulse_event();
    pulse_event();
    check(io.pending_count, 2'd2, "ar_pend2");
    #2;
    rst = 1'b1;
    #1;
    check(io.led_out, 1'b0, "ar_led");
    check(io.busy, 1'b0, "ar_busy");
    check(io.pending_count, 2'd0, "ar_pend");
    check(io.overflow, 1'b0, "ar_ovf");
    step();
    rst = 1'b0;
    step();
    check(io.busy, 1'b0, "ar_after_busy");

    // Event at the second ON tick: entry at edge n+1 from a tick edge n,
    // ticks at n+4, n+8, n+12; event sampled at n+8.
    while (cyc % 4 != 0) step();
    pulse_event();
    repeat (6) step();
    io.event_pulse = 1'b1;
    step();
    io.event_pulse = 1'b0;
`ifdef LED_STRETCH_RETRIGGER_EN
    check(io.pending_count, 2'd0, "rt_pend");
`else
    check(io.pending_count, 2'd1, "rt_pend");
`endif
    measure_high(len, 40);
    len = len + 7;
`ifdef LED_STRETCH_RETRIGGER_EN
    check(len, 19, "rt_on_len");
`else
    check(len, 11, "rt_on_len");
`endif
    wait_idle(80, "rt_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
